muldiv_sequencer: RTL

- Multi-cycle sequencer for the RV32M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU. Decode raises start when ALUOp=2'b10 and funct7=7'b0000001.
- The block stalls the PC while a radix-2 shift-add multiply or restoring divide iterates.
- It returns one XLEN result with a single-cycle done pulse.

---
 rtl/muldiv_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer for the RV32M multiply/divide ops. It runs beside the single-cycle ALU,
// holds the PC through stall while a radix-2 shift-add multiply or restoring divide iterates,
// and returns one XLEN result with a one-cycle done pulse.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst_n   - asynchronous active-low reset
//   start   - level request from decode, held while the M-instruction is current
//   funct3  - op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   op_a    - rs1 (multiplicand / dividend)
//   op_b    - rs2 (multiplier / divisor)
//   flush   - synchronous abort of the in-flight op
//   busy    - high while iterating
//   done    - one-cycle completion pulse
//   result  - valid while done is high, holds its last value otherwise
//   stall   - start & ~done
module muldiv_sequencer #(
  parameter int unsigned XLEN     = 32,
  parameter bit          DIV_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StMulRun, StDivRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Request decode, only meaningful in the accepting cycle.
  logic            accept, sign_a, sign_b, b_zero, ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  assign accept = (state_q == StIdle) & start & ~flush;
  assign sign_a = op_a[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                                  (funct3 == 3'b100) | (funct3 == 3'b110));
  assign sign_b = op_b[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                                  (funct3 == 3'b110));
  assign mag_a  = sign_a ? -op_a : op_a;
  assign mag_b  = sign_b ? -op_b : op_b;
  assign b_zero = (op_b == '0);
  assign ovf    = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
  assign fast   = DIV_FAST & funct3[2] & (b_zero | ovf);
  // ovf and b_zero are mutually exclusive (ovf needs an all-ones divisor).
  assign fast_res = ovf ? (funct3[1] ? '0 : op_a) : (funct3[1] ? op_a : '1);

  // Multiply step: acc = {product high, multiplier being consumed from the LSB}.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: acc = {partial remainder, dividend shifting out / quotient shifting in}.
  logic [XLEN:0]     rem_sh, rem_sub;
  logic              rem_ge;
  logic [2*XLEN-1:0] div_next;
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign rem_sub  = rem_sh - {1'b0, b_q};
  assign rem_ge   = (rem_sh >= {1'b0, b_q});
  assign div_next = {(rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};

  // Final sign fix-up applied on the edge that enters StDone.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, div_mag, div_res;
  assign prod    = neg_q ? -acc_q : acc_q;
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign div_mag = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign div_res = neg_q ? -div_mag : div_mag;

  logic run_last;
  assign run_last = (cnt_q == CntW'(XLEN));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (fast)           state_d = StDone;
          else if (funct3[2]) state_d = StDivRun;
          else                state_d = StMulRun;
        end
      end
      StMulRun, StDivRun: begin
        if (flush)         state_d = StIdle;
        else if (run_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = funct3;
          cnt_d = '0;
          b_d   = funct3[2] ? mag_b : mag_a;
          acc_d = {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
          // x/0 must give all-ones even for a negative signed dividend, so never negate it.
          if (funct3[2]) neg_d = funct3[1] ? sign_a : ((sign_a ^ sign_b) & ~b_zero);
          else           neg_d = sign_a ^ sign_b;
          if (fast) result_d = fast_res;
        end
      end
      StMulRun: begin
        if (!flush) begin
          if (run_last) begin
            result_d = mul_res;
          end else begin
            acc_d = mul_next;
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDivRun: begin
        if (!flush) begin
          if (run_last) begin
            result_d = div_res;
          end else begin
            acc_d = div_next;
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy   = (state_q == StMulRun) | (state_q == StDivRun);
    done   = (state_q == StDone);
    result = result_q;
    stall  = start & ~done;
  end

endmodule
